// File: rtl/dmem_pkg.sv
// Shared types and default parameters for the data-memory responder.
//   state_e             : responder FSM states
//   DEFAULT_DEPTH_WORDS : default number of 32-bit storage words
//   DEFAULT_LATENCY     : default cycles from accept to first rsp_valid
package dmem_pkg;

  localparam int unsigned DEFAULT_DEPTH_WORDS = 1024;
  localparam int unsigned DEFAULT_LATENCY     = 2;
  localparam int unsigned WORD_W              = 32;
  localparam int unsigned LANES               = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage with per-byte-lane write enables and combinational read.
// Contents are deliberately not reset.
//   clk     : write clock
//   wr_be   : byte-lane write enables (lane i = wr_data[8i+7:8i])
//   wr_idx  : word index written
//   wr_data : write data, lane aligned
//   rd_idx  : word index read
//   rd_data : combinational read data
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  localparam int unsigned AW = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic [LANES-1:0]  wr_be,
  input  logic [AW-1:0]     wr_idx,
  input  logic [WORD_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_idx,
  output logic [WORD_W-1:0] rd_data
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  // Lane-masked write; disabled lanes keep their contents.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(LANES); i++) begin
      if (wr_be[i]) begin
        mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with fixed response latency.
//   clk       : rising-edge clock
//   n_rst     : asynchronous reset, active HIGH despite its name
//   req_*     : request channel (valid/ready), we=1 store, be = lane enables
//   rsp_*     : response channel (valid/ready), rdata for loads, err = out of range
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  parameter int unsigned LATENCY     = DEFAULT_LATENCY
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic [LANES-1:0]  req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned AW       = $clog2(DEPTH_WORDS);
  localparam int unsigned CW       = $clog2(LATENCY) + 1;
  localparam int unsigned CNT_LOAD = (LATENCY > 1) ? LATENCY - 2 : 0;
  localparam bit          DIRECT   = (LATENCY == 1);
  // Byte-address limit; addr[31:2] >= DEPTH_WORDS is the same as addr >= 4*DEPTH_WORDS.
  localparam logic [32:0] LIMIT    = 33'(DEPTH_WORDS) << 2;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               we_q, we_d;
  logic               err_q, err_d;
  logic [AW-1:0]      idx_q, idx_d;
  logic [WORD_W-1:0]  wdata_q, wdata_d;
  logic [LANES-1:0]   be_q, be_d;

  logic               accept_c;
  logic               in_range_c;
  logic [LANES-1:0]   mem_be_c;
  logic [AW-1:0]      mem_idx_c;
  logic [WORD_W-1:0]  mem_wdata_c;
  logic [WORD_W-1:0]  mem_rdata_c;

  assign in_range_c = ({1'b0, req_addr} < LIMIT);
  assign accept_c   = req_valid && req_ready;

  // State register and latched request.
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
    end
  end

  // Next state, request latch and the store commit on the edge entering RESP.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    err_d       = err_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    mem_be_c    = '0;
    mem_idx_c   = idx_q;
    mem_wdata_c = wdata_q;

    unique case (state_q)
      IDLE: begin
        if (accept_c) begin
          we_d    = req_we;
          err_d   = !in_range_c;
          idx_d   = req_addr[AW+1:2];
          wdata_d = req_wdata;
          be_d    = req_be;
          if (DIRECT) begin
            // With no WAIT stage the accept edge is the commit edge, so use live inputs.
            state_d = RESP;
            if (req_we && in_range_c) begin
              mem_be_c    = req_be;
              mem_idx_c   = req_addr[AW+1:2];
              mem_wdata_c = req_wdata;
            end
          end else begin
            state_d = WAIT;
            cnt_d   = CW'(CNT_LOAD);
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          if (we_q && !err_q) begin
            mem_be_c = be_q;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the registered state so they drop the instant reset asserts.
  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    rsp_rdata = '0;
    if (state_q == IDLE && !n_rst) begin
      req_ready = 1'b1;
    end
    if (state_q == RESP) begin
      rsp_valid = 1'b1;
      rsp_err   = err_q;
      if (!we_q && !err_q) begin
        rsp_rdata = mem_rdata_c;
      end
    end
  end

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk     (clk),
    .wr_be   (mem_be_c),
    .wr_idx  (mem_idx_c),
    .wr_data (mem_wdata_c),
    .rd_idx  (idx_q),
    .rd_data (mem_rdata_c)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed cases, randomized traffic
// against a word-array model, reset behaviour and a LATENCY=1 back-to-back instance.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned LAT   = 2;
  localparam int unsigned NW    = 64;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  logic        req_valid1, req_ready1, req_we1;
  logic [31:0] req_addr1, req_wdata1;
  logic [3:0]  req_be1;
  logic        rsp_valid1, rsp_err1;
  logic        rsp_ready1;
  logic [31:0] rsp_rdata1;

  int errors = 0;
  int checks = 0;
  logic [31:0] model [NW];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) u_dut (
    .clk(clk), .n_rst(n_rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) u_dut1 (
    .clk(clk), .n_rst(n_rst),
    .req_valid(req_valid1), .req_ready(req_ready1), .req_we(req_we1),
    .req_addr(req_addr1), .req_wdata(req_wdata1), .req_be(req_be1),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1),
    .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1)
  );

  // Reference: apply a transaction to the word model and return the expected response.
  function automatic void model_txn(input logic we, input logic [31:0] addr,
                                    input logic [31:0] wdata, input logic [3:0] be,
                                    output logic [31:0] exp_rdata, output logic exp_err);
    int unsigned w;
    w = addr / 4;
    exp_err   = (w >= DEPTH);
    exp_rdata = 32'h0;
    if (!exp_err) begin
      if (we) begin
        for (int i = 0; i < 4; i++)
          if (be[i]) model[w][8*i +: 8] = wdata[8*i +: 8];
      end else begin
        exp_rdata = model[w];
      end
    end
  endfunction

  // Drive one request, wait for its response, hold rsp_ready low for 'hold' cycles.
  task automatic drive_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] be, input int hold,
                           output int lat, output logic [31:0] rdata, output logic err,
                           output bit stable, output bit timeout);
    int n;
    timeout = 0; stable = 1; lat = 0; rdata = 32'h0; err = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      timeout = 1; req_valid = 1'b0;
      return;
    end
    @(negedge clk);
    // Scramble inputs after accept; the latched request must be unaffected.
    req_valid = 1'b0; req_we = 1'($urandom); req_addr = $urandom;
    req_wdata = $urandom; req_be = 4'($urandom);
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid) begin
      timeout = 1;
      return;
    end
    rdata = rsp_rdata; err = rsp_err;
    for (int i = 0; i < hold; i++) begin
      if (rsp_valid !== 1'b1 || rsp_rdata !== rdata || rsp_err !== err || req_ready !== 1'b0)
        stable = 0;
      @(negedge clk);
    end
    if (rsp_valid !== 1'b1 || rsp_rdata !== rdata || rsp_err !== err || req_ready !== 1'b0)
      stable = 0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) stable = 0;
  endtask

  task automatic test_reset();
    n_rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    rsp_ready = 1'b0;
    req_valid1 = 1'b0; req_we1 = 1'b0; req_addr1 = '0; req_wdata1 = '0; req_be1 = '0;
    rsp_ready1 = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({req_ready, rsp_valid, rsp_err, rsp_rdata} !== 35'h0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b err=%b rdata=%h, want all 0",
               req_ready, rsp_valid, rsp_err, rsp_rdata);
    end
    n_rst = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got rdy=%b vld=%b, want 1 0", req_ready, rsp_valid);
    end
  endtask

  task automatic test_init();
    int lat; logic [31:0] rd; logic er; bit st, to;
    logic [31:0] er_d; logic ee;
    int bad = 0;
    for (int w = 0; w < int'(NW); w++) begin
      logic [31:0] d;
      d = $urandom;
      model_txn(1'b1, 32'(w * 4), d, 4'hF, er_d, ee);
      drive_txn(1'b1, 32'(w * 4), d, 4'hF, 0, lat, rd, er, st, to);
      if (to || er !== 1'b0 || rd !== 32'h0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL init_stores: got %0d bad store responses, want 0", bad);
    end
  endtask

  task automatic test_directed();
    int lat; logic [31:0] rd, er_d; logic er, ee; bit st, to;
    model_txn(1'b1, 32'h10, 32'hA1B2C3D4, 4'hF, er_d, ee);
    drive_txn(1'b1, 32'h10, 32'hA1B2C3D4, 4'hF, 0, lat, rd, er, st, to);
    checks++;
    if (to || lat !== 2 || rd !== 32'h0 || er !== 1'b0) begin
      errors++;
      $display("FAIL store_full: got to=%0d lat=%0d rdata=%h err=%b, want 0 2 0 0", to, lat, rd, er);
    end
    drive_txn(1'b0, 32'h10, 32'h0, 4'h0, 0, lat, rd, er, st, to);
    checks++;
    if (to || lat !== 2) begin
      errors++;
      $display("FAIL load_latency: got to=%0d lat=%0d, want 0 2", to, lat);
    end
    checks++;
    if (rd !== 32'hA1B2C3D4 || er !== 1'b0) begin
      errors++;
      $display("FAIL load_full: got rdata=%h err=%b, want a1b2c3d4 0", rd, er);
    end
    model_txn(1'b1, 32'h10, 32'h00EE0000, 4'b0100, er_d, ee);
    drive_txn(1'b1, 32'h10, 32'h00EE0000, 4'b0100, 0, lat, rd, er, st, to);
    drive_txn(1'b0, 32'h13, 32'h0, 4'h0, 0, lat, rd, er, st, to);
    checks++;
    if (to || rd !== 32'hA1EEC3D4 || er !== 1'b0) begin
      errors++;
      $display("FAIL partial_store: got rdata=%h err=%b, want a1eec3d4 0", rd, er);
    end
    drive_txn(1'b0, 32'h1000, 32'h0, 4'h0, 0, lat, rd, er, st, to);
    checks++;
    if (to || rd !== 32'h0 || er !== 1'b1) begin
      errors++;
      $display("FAIL oor_load: got rdata=%h err=%b, want 0 1", rd, er);
    end
    drive_txn(1'b1, 32'h1FFC, 32'hFFFFFFFF, 4'hF, 0, lat, rd, er, st, to);
    checks++;
    if (to || rd !== 32'h0 || er !== 1'b1) begin
      errors++;
      $display("FAIL oor_store: got rdata=%h err=%b, want 0 1", rd, er);
    end
    drive_txn(1'b0, 32'h0, 32'h0, 4'h0, 0, lat, rd, er, st, to);
    checks++;
    if (to || rd !== model[0] || er !== 1'b0) begin
      errors++;
      $display("FAIL after_oor: got rdata=%h err=%b, want %h 0", rd, er, model[0]);
    end
    drive_txn(1'b0, 32'hFFC, 32'h0, 4'h0, 0, lat, rd, er, st, to);
    checks++;
    if (to || er !== 1'b0) begin
      errors++;
      $display("FAIL last_word: got err=%b, want 0", er);
    end
  endtask

  task automatic test_backpressure();
    int lat; logic [31:0] rd; logic er; bit st, to;
    drive_txn(1'b0, 32'h14, 32'h0, 4'h0, 5, lat, rd, er, st, to);
    checks++;
    if (to || !st || rd !== model[5] || er !== 1'b0) begin
      errors++;
      $display("FAIL backpressure: got to=%0d stable=%0d rdata=%h err=%b, want 0 1 %h 0",
               to, st, rd, er, model[5]);
    end
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] rd; logic er; bit st, to;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hDEADBEEF; req_be = 4'hF;
    @(negedge clk);
    req_valid = 1'b0;
    n_rst = 1'b1;
    #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_err, rsp_rdata} !== 35'h0) begin
      errors++;
      $display("FAIL reset_in_wait: got rdy=%b vld=%b err=%b rdata=%h, want all 0",
               req_ready, rsp_valid, rsp_err, rsp_rdata);
    end
    @(negedge clk);
    n_rst = 1'b0;
    drive_txn(1'b0, 32'h20, 32'h0, 4'h0, 0, lat, rd, er, st, to);
    checks++;
    if (to || rd !== model[8] || er !== 1'b0) begin
      errors++;
      $display("FAIL discarded_store: got rdata=%h err=%b, want %h 0", rd, er, model[8]);
    end
    // Reset while a load response is being held.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== model[4]) begin
      errors++;
      $display("FAIL pre_reset_resp: got vld=%b rdata=%h, want 1 %h", rsp_valid, rsp_rdata, model[4]);
    end
    n_rst = 1'b1;
    #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_err, rsp_rdata} !== 35'h0) begin
      errors++;
      $display("FAIL reset_in_resp: got rdy=%b vld=%b err=%b rdata=%h, want all 0",
               req_ready, rsp_valid, rsp_err, rsp_rdata);
    end
    @(negedge clk);
    n_rst = 1'b0;
  endtask

  task automatic test_random();
    int lat; logic [31:0] rd, exp_rd; logic er, exp_er; bit st, to;
    int bad = 0;
    for (int n = 0; n < 200; n++) begin
      logic we; logic [31:0] a, d; logic [3:0] be; int hold;
      we = 1'($urandom); d = $urandom; be = 4'($urandom); hold = $urandom_range(0, 3);
      if ($urandom_range(0, 7) == 0)
        a = {30'($urandom_range(DEPTH, 32'h3FFF_FFFF)), 2'($urandom)};
      else
        a = 32'($urandom_range(0, NW - 1) * 4 + $urandom_range(0, 3));
      model_txn(we, a, d, be, exp_rd, exp_er);
      drive_txn(we, a, d, be, hold, lat, rd, er, st, to);
      checks++;
      if (to || lat !== int'(LAT) || !st || rd !== exp_rd || er !== exp_er) begin
        errors++; bad++;
        if (bad < 10)
          $display("FAIL random_txn[%0d]: we=%b a=%h got to=%0d lat=%0d st=%0d rdata=%h err=%b, want lat=%0d rdata=%h err=%b",
                   n, we, a, to, lat, st, rd, er, LAT, exp_rd, exp_er);
      end
    end
  endtask

  task automatic test_back_to_back_lat1();
    logic [31:0] d [4];
    for (int i = 0; i < 4; i++) d[i] = $urandom;
    @(negedge clk);
    for (int k = 0; k < 16; k++) begin
      int t;
      t = k / 2;
      if (k % 2 == 0) begin
        req_valid1 = 1'b1;
        req_be1    = 4'hF;
        req_we1    = (t < 4);
        req_addr1  = 32'(((t < 4) ? t : t - 4) * 4 + 32'h40);
        req_wdata1 = (t < 4) ? d[t] : 32'($urandom);
        checks++;
        if (req_ready1 !== 1'b1 || rsp_valid1 !== 1'b0) begin
          errors++;
          $display("FAIL lat1_idle[%0d]: got rdy=%b vld=%b, want 1 0", k, req_ready1, rsp_valid1);
        end
      end else begin
        logic [31:0] exp;
        exp = (t < 4) ? 32'h0 : d[t-4];
        checks++;
        if (req_ready1 !== 1'b0 || rsp_valid1 !== 1'b1 || rsp_rdata1 !== exp || rsp_err1 !== 1'b0) begin
          errors++;
          $display("FAIL lat1_resp[%0d]: got rdy=%b vld=%b rdata=%h err=%b, want 0 1 %h 0",
                   k, req_ready1, rsp_valid1, rsp_rdata1, rsp_err1, exp);
        end
      end
      @(negedge clk);
    end
    req_valid1 = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_init();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_back_to_back_lat1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
